// File: rtl/remote_update_pkg.sv
// Shared types and address fields for the remote-update sequencer.
package remote_update_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_TRIG = 3'd1,
        RD_WAIT = 3'd2,
        WR_ADDR = 3'd3,
        WR_WDEN = 3'd4,
        RECFG   = 3'd5,
        FINISH  = 3'd6
    } ru_state_e;

    localparam logic [1:0] SRC_CUR   = 2'b00;
    localparam logic [1:0] SRC_INPUT = 2'b10;

    localparam logic [2:0] PARAM_TRIG = 3'b000;
    localparam logic [2:0] PARAM_WDEN = 3'b011;
    localparam logic [2:0] PARAM_PAGE = 3'b100;

    function automatic logic [5:0] ru_addr(input logic [1:0] src, input logic [2:0] param);
        return {src, 1'b0, param};
    endfunction

endpackage

// File: rtl/remote_update_sequencer_timeout_counter.sv
// Per-state watchdog: counts cycles spent in a bus state and flags the abort point.
module ru_timeout_counter #(
    parameter int TO_W = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    // Saturates at all-ones so a disabled limit never wraps back into range.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (limit != '0) && (count_q == limit - 1'b1);

endmodule

// File: rtl/remote_update_sequencer.sv
// Avalon-MM master running the trigger-read / page-write / watchdog-write / reconfig
// sequence against the remote-update slave behind a single start/done handshake.
//
// state   | meaning
// IDLE    | waiting for cmd_start
// RD_TRIG | read of trigger condition presented
// RD_WAIT | waiting for readdatavalid
// WR_ADDR | boot page write presented
// WR_WDEN | watchdog enable write presented
// RECFG   | waiting for core idle before reconfig pulse
// FINISH  | done pulse, back to IDLE
module remote_update_sequencer
    import remote_update_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13,
    parameter int WDOG_EN        = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic [21:0] cmd_page_addr,
    input  logic        cmd_reconfig,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [28:0] status_trigger,
    output logic [5:0]  av_address,
    output logic        av_read,
    output logic        av_write,
    output logic [31:0] av_writedata,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    input  logic        av_readdatavalid,
    output logic        ru_reconfig
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic            WDEN_BIT = (WDOG_EN & 1) != 0;

    ru_state_e   state_q, state_d;
    logic [21:0] page_q, page_d;
    logic        recfg_q, recfg_d;
    logic [28:0] trig_q, trig_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        ru_q, ru_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic in_bus;
    logic to_expired;
    logic unused_rd_hi;

    assign unused_rd_hi = ^av_readdata[31:29];
    assign in_bus = (state_q == RD_TRIG) || (state_q == RD_WAIT) || (state_q == WR_ADDR) ||
                    (state_q == WR_WDEN) || (state_q == RECFG);

    ru_timeout_counter #(.TO_W(TO_W)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_d != state_q),
        .enable  (in_bus),
        .limit   (TO_LIMIT),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            page_q  <= '0;
            recfg_q <= 1'b0;
            trig_q  <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ru_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            recfg_q <= recfg_d;
            trig_q  <= trig_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ru_q    <= ru_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        recfg_d = recfg_q;
        trig_d  = trig_q;
        error_d = error_q;
        ru_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    page_d  = cmd_page_addr;
                    recfg_d = cmd_reconfig;
                    error_d = 1'b0;
                    state_d = RD_TRIG;
                end
            end
            RD_TRIG: if (!av_waitrequest) state_d = RD_WAIT;
            RD_WAIT: begin
                if (av_readdatavalid) begin
                    trig_d  = av_readdata[28:0];
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR: if (!av_waitrequest) state_d = WR_WDEN;
            WR_WDEN: if (!av_waitrequest) state_d = recfg_q ? RECFG : FINISH;
            RECFG: begin
                if (!av_waitrequest) begin
                    ru_d    = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over any progress made in the same cycle.
        if (in_bus && to_expired) begin
            state_d = FINISH;
            trig_d  = trig_q;
            error_d = 1'b1;
            ru_d    = 1'b0;
        end
    end

    always_comb begin
        busy_d  = (state_d != IDLE) && (state_d != FINISH);
        done_d  = (state_d == FINISH);
        rd_d    = (state_d == RD_TRIG);
        wr_d    = (state_d == WR_ADDR) || (state_d == WR_WDEN);
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            RD_TRIG: addr_d = ru_addr(SRC_CUR, PARAM_TRIG);
            WR_ADDR: begin
                addr_d  = ru_addr(SRC_INPUT, PARAM_PAGE);
                wdata_d = {10'd0, page_d};
            end
            WR_WDEN: begin
                addr_d  = ru_addr(SRC_INPUT, PARAM_WDEN);
                wdata_d = {31'd0, WDEN_BIT};
            end
            default: ;
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign status_trigger = trig_q;
    assign av_address     = addr_q;
    assign av_read        = rd_q;
    assign av_write       = wr_q;
    assign av_writedata   = wdata_q;
    assign ru_reconfig    = ru_q;

endmodule

// File: tb/tb_remote_update_sequencer.sv
// Randomized bench: a stalling Avalon slave model logs accepted accesses, and each
// command is checked against bus order, hold lengths, latency and status rules.
module tb_remote_update_sequencer;

    localparam int TA = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_reconfig = 1'b0;
    logic [21:0] cmd_page_addr = '0;
    logic        av_waitrequest = 1'b0;
    logic        av_readdatavalid = 1'b0;
    logic [31:0] av_readdata = '0;

    logic [1:0]  start_v, busy_v, done_v, err_v, rd_v, wr_v, ru_v;
    logic [5:0]  addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [28:0] trig_v  [2];

    logic        s_busy, s_done, s_err, s_rd, s_wr, s_ru;
    logic [5:0]  s_addr;
    logic [31:0] s_wdata;
    logic [28:0] s_trig;

    always #5 clk = ~clk;

    assign start_v = {cmd_start & sel, cmd_start & ~sel};
    assign s_busy  = busy_v[sel];
    assign s_done  = done_v[sel];
    assign s_err   = err_v[sel];
    assign s_rd    = rd_v[sel];
    assign s_wr    = wr_v[sel];
    assign s_ru    = ru_v[sel];
    assign s_addr  = addr_v[sel];
    assign s_wdata = wdata_v[sel];
    assign s_trig  = trig_v[sel];

    // A: short timeout, watchdog bit 0. B: timeout disabled, watchdog bit 1.
    remote_update_sequencer #(.TIMEOUT_CYCLES(TA), .TO_W(5), .WDOG_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_start(start_v[0]), .cmd_page_addr(cmd_page_addr),
        .cmd_reconfig(cmd_reconfig), .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]),
        .status_trigger(trig_v[0]), .av_address(addr_v[0]), .av_read(rd_v[0]),
        .av_write(wr_v[0]), .av_writedata(wdata_v[0]), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid), .ru_reconfig(ru_v[0])
    );

    remote_update_sequencer #(.TIMEOUT_CYCLES(0), .TO_W(13), .WDOG_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_start(start_v[1]), .cmd_page_addr(cmd_page_addr),
        .cmd_reconfig(cmd_reconfig), .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]),
        .status_trigger(trig_v[1]), .av_address(addr_v[1]), .av_read(rd_v[1]),
        .av_write(wr_v[1]), .av_writedata(wdata_v[1]), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid), .ru_reconfig(ru_v[1])
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Slave model state
    int          w_first = 0, w_norm = 0;
    int          hold = 0, acc_idx = 0;
    int          done_cnt = 0, ru_cnt = 0, ru_pos = 0;
    logic        rdv_en = 1'b1, rdv_pend = 1'b0, stable = 1'b1;
    logic [31:0] rdata = '0;
    logic [5:0]  f_addr;
    logic [31:0] f_data;
    logic [1:0]  f_rw;
    logic [38:0] log_q  [$];
    int          hold_q [$];
    logic        stab_q [$];

    initial begin
        forever begin
            @(negedge clk);
            av_readdatavalid = 1'b0;
            av_readdata      = $urandom;
            if (!rst_n) begin
                hold           = 0;
                rdv_pend       = 1'b0;
                acc_idx        = 0;
                av_waitrequest = 1'b0;
            end else begin
                if (!s_busy) acc_idx = 0;
                if (s_done) done_cnt++;
                if (s_ru) begin
                    ru_cnt++;
                    ru_pos = log_q.size();
                end
                if (rdv_pend && rdv_en) begin
                    av_readdatavalid = 1'b1;
                    av_readdata      = rdata;
                end
                rdv_pend = 1'b0;
                if (s_rd || s_wr) begin
                    if (hold == 0) begin
                        f_addr = s_addr;
                        f_data = s_wdata;
                        f_rw   = {s_rd, s_wr};
                        stable = 1'b1;
                    end else if (f_addr != s_addr || f_data != s_wdata || f_rw != {s_rd, s_wr}) begin
                        stable = 1'b0;
                    end
                    if (s_rd && s_wr) stable = 1'b0;
                    hold++;
                    if (hold > ((acc_idx == 0) ? w_first : w_norm)) begin
                        av_waitrequest = 1'b0;
                        log_q.push_back({s_wr, s_addr, s_wdata});
                        hold_q.push_back(hold);
                        stab_q.push_back(stable);
                        if (s_rd) rdv_pend = 1'b1;
                        hold = 0;
                        acc_idx++;
                    end else begin
                        av_waitrequest = 1'b1;
                    end
                end else begin
                    av_waitrequest = 1'b0;
                end
            end
        end
    end

    task automatic run_cmd(input logic [21:0] page, input logic rc, input int wf, input int wn,
                           input logic rdv_on, input logic poke, input logic [31:0] rd,
                           input int budget);
        int          n, base_log, base_done, base_ru, exp_lat, n_acc;
        logic        seen;
        logic [38:0] exp_e [3];
        @(negedge clk);
        #2;
        w_first   = wf;
        w_norm    = wn;
        rdv_en    = rdv_on;
        rdata     = rd;
        base_log  = log_q.size();
        base_done = done_cnt;
        base_ru   = ru_cnt;
        cmd_start     = 1'b1;
        cmd_page_addr = page;
        cmd_reconfig  = rc;
        @(posedge clk);
        #1;
        cmd_start     = 1'b0;
        cmd_page_addr = 22'($urandom);
        cmd_reconfig  = 1'($urandom);
        chk("busy_on", s_busy, 1);
        chk("err_clr", s_err, 0);
        // n counts clock cycles from the one presenting cmd_start through the done cycle
        n    = 2;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            cmd_start = poke && (n == 4);
            if (poke && n == 4) cmd_page_addr = ~page;
            seen = s_done;
        end
        cmd_start = 1'b0;
        if (rdv_on) exp_lat = (wf + 1) + 2 * (wn + 1) + 3 + int'(rc);
        else        exp_lat = (wf + 1) + TA + 2;
        chk("done_seen", seen, 1);
        chk("latency", n, exp_lat);
        chk("error", s_err, !rdv_on);
        chk("bus_idle_at_done", {s_rd, s_wr, s_busy}, 0);
        if (rdv_on) chk("status_trigger", s_trig, rd[28:0]);
        repeat (2) @(posedge clk);
        #1;
        chk("one_done", done_cnt - base_done, 1);
        chk("idle_after", s_busy, 0);
        chk("ru_count", ru_cnt - base_ru, (rdv_on && rc) ? 1 : 0);
        if (rdv_on && rc) chk("ru_after_wden", ru_pos - base_log, 3);
        n_acc = rdv_on ? 3 : 1;
        chk("n_access", log_q.size() - base_log, n_acc);
        exp_e[0] = {1'b0, 6'h00, 32'h0};
        exp_e[1] = {1'b1, 6'h24, 10'd0, page};
        exp_e[2] = {1'b1, 6'h23, 31'd0, sel};
        for (int i = 0; i < n_acc && base_log + i < log_q.size(); i++) begin
            chk("acc_kind", log_q[base_log + i][38:32], exp_e[i][38:32]);
            if (i > 0) chk("acc_data", log_q[base_log + i][31:0], exp_e[i][31:0]);
            chk("acc_hold", hold_q[base_log + i], ((i == 0) ? wf : wn) + 1);
            chk("acc_stable", stab_q[base_log + i], 1);
        end
    endtask

    initial begin
        int n, base;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {s_busy, s_done, s_err, s_rd, s_wr, s_ru}, 0);
        chk("reset_bus", {s_addr, s_wdata, s_trig}, 0);
        rst_n = 1'b1;

        run_cmd(22'h12345, 1'b0, 0, 0, 1'b1, 1'b0, 32'h0000_0005, 100);
        run_cmd(22'h12345, 1'b1, 3, 3, 1'b1, 1'b0, 32'h0000_0005, 100);
        run_cmd(22'($urandom), 1'($urandom), 2, 0, 1'b0, 1'b0, $urandom, 100);
        run_cmd(22'h3FFFFF, 1'b0, 1, 2, 1'b1, 1'b1, $urandom, 100);
        for (int i = 0; i < 10; i++) begin
            run_cmd(22'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                    1'b1, 1'($urandom), $urandom, 100);
        end

        // reset while the page write is stalled
        w_first = 10;
        w_norm  = 10;
        rdv_en  = 1'b1;
        rdata   = $urandom;
        base    = done_cnt;
        @(negedge clk);
        #2;
        cmd_start     = 1'b1;
        cmd_page_addr = 22'h2AAAA;
        cmd_reconfig  = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        n = 0;
        while (!(s_wr && s_addr == 6'h24) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_reach_wr", n < 100, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ctl", {s_busy, s_done, s_err, s_rd, s_wr, s_ru}, 0);
        chk("rst_bus", {s_addr, s_wdata, s_trig}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - base, 0);
        run_cmd(22'($urandom), 1'b1, 0, 1, 1'b1, 1'b0, $urandom, 100);

        sel = 1'b1;
        run_cmd(22'($urandom), 1'b1, 10000, 0, 1'b1, 1'b0, $urandom, 20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/remote_update_sequencer.md
Name: remote_update_sequencer

Overview:
- Avalon-MM master that sits directly upstream of the remote-update Avalon slave and drives its bus.
- On one command it runs a fixed remote-update sequence:
  - read the reconfig trigger condition;
  - write the boot page address;
  - write the watchdog enable;
  - optionally pulse reconfig to the remote-update core.
- Gives firmware or boot logic a single start/done handshake with error reporting, instead of raw register traffic.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles in any bus state before abort. 0 disables the timeout.
- TO_W, 13: timeout counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.
- WDOG_EN, 0: value written to the watchdog-enable register (bit 0 of writedata).

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  synchronous reset, active-low.
- cmd_start  in  1  command request. Sampled only when busy=0.
- cmd_page_addr  in  22  boot page address to program.
- cmd_reconfig  in  1  1 = trigger reconfiguration after programming.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence ends (success or abort).
- error  out  1  sticky timeout flag. Cleared on the next accepted cmd_start.
- status_trigger  out  29  captured readdata[28:0] of the trigger-condition read.
- av_address  out  6  formed as {source[1:0], 1'b0, param[2:0]}.
- av_read  out  1  Avalon read.
- av_write  out  1  Avalon write.
- av_writedata  out  32  Avalon write data.
- av_waitrequest  in  1  slave stall.
- av_readdata  in  32  read data.
- av_readdatavalid  in  1  read data valid.
- ru_reconfig  out  1  one-cycle reconfig pulse to the remote-update core.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, counter 0. Reset mid-sequence aborts immediately with no done pulse.
- All outputs are registered. Outputs are decoded from next-state at each edge.
- State IDLE:
  - If cmd_start=1: latch cmd_page_addr and cmd_reconfig, clear error, set busy=1, go RD_TRIG.
  - cmd_start while busy=1 is ignored.
- State RD_TRIG:
  - av_read=1, av_address=6'b000000 (source 00, param 000).
  - Held stable until an edge with av_waitrequest=0, then av_read drops and state goes RD_WAIT.
- State RD_WAIT:
  - av_read=0.
  - On an edge with av_readdatavalid=1: status_trigger <= av_readdata[28:0], go WR_ADDR.
  - av_readdatavalid outside RD_WAIT is ignored.
- State WR_ADDR:
  - av_write=1, av_address=6'b100100 (source 10, param 100), av_writedata={10'd0, latched page}.
  - Held until av_waitrequest=0, then go WR_WDEN.
- State WR_WDEN:
  - av_write=1, av_address=6'b100011, av_writedata={31'd0, WDOG_EN[0]}.
  - When accepted: go RECFG if the latched reconfig flag is 1, else FINISH.
- State RECFG:
  - Waits until av_waitrequest=0 (core idle).
  - Then ru_reconfig=1 for exactly one cycle, go FINISH.
- State FINISH:
  - done=1 for one cycle, busy=0 in the same cycle, go IDLE.
  - A new cmd_start is accepted from the following cycle.
- av_read and av_write are never asserted together.
- Address and writedata are constant while a command is held under waitrequest.
- Timeout:
  - The counter clears on every state entry and increments each cycle in RD_TRIG, RD_WAIT, WR_ADDR, WR_WDEN and RECFG.
  - When it reaches TIMEOUT_CYCLES-1 (with TIMEOUT_CYCLES≠0): deassert av_read, av_write and ru_reconfig; set error=1; go FINISH (done pulses).
  - The counter saturates and never wraps.
- Minimum latency with waitrequest always 0 and readdatavalid one cycle after read acceptance:
  - cmd_start edge to done edge = 6 cycles without reconfig, 7 cycles with reconfig.

Decomposition:
- Package remote_update_pkg:
  - state enum (IDLE, RD_TRIG, RD_WAIT, WR_ADDR, WR_WDEN, RECFG, FINISH);
  - SRC_CUR=2'b00, SRC_INPUT=2'b10;
  - PARAM_TRIG=3'b000, PARAM_WDEN=3'b011, PARAM_PAGE=3'b100;
  - an address-build function.
- Sub-module ru_timeout_counter (clear, enable, limit, expired; width TO_W), instantiated once.

Test Plan:
- cmd_start with page=22'h12345, reconfig=0, waitrequest=0, readdatavalid one cycle after read with readdata=32'h0000_0005 -> required bus order:
  - read @6'h00;
  - write @6'h24 with data 32'h0001_2345;
  - write @6'h23 with data 0.
  Then status_trigger=29'h5, done pulse 6 cycles after start, error=0, ru_reconfig never asserted.
- Same stimulus with reconfig=1 and waitrequest held 1 for 3 cycles on each access -> each command held stable for 4 cycles; one ru_reconfig pulse after the WDEN write; done follows.
- TIMEOUT_CYCLES=16, readdatavalid never arrives -> abort: av_read low, error=1, done pulse 16 cycles after RD_WAIT entry; the next cmd_start clears error.
- cmd_start pulsed during an active sequence -> ignored; the latched page is unchanged and exactly one done pulse occurs.
- rst_n=0 for one cycle while in WR_ADDR with waitrequest=1 -> next cycle all outputs 0, busy=0, no done pulse; a new command then runs normally.
- TIMEOUT_CYCLES=0 with waitrequest stuck 1 for 10000 cycles -> no abort; the sequence completes normally once waitrequest drops.
